// File: rtl/ahb_dphase_mux.sv
// N:1 AHB-Lite data-phase response mux with a built-in default slave.
// Zero-cycle slave-to-master path. Select is captured only while hready is high and held through waits.
module ahb_dphase_mux #(
  parameter int NUM = 6,
  parameter int DW  = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NUM-1:0]    hsel,
  input  logic              htrans_vld,
  input  logic [NUM*DW-1:0] hrdata_bus,
  input  logic [NUM-1:0]    hreadyout_bus,
  input  logic [NUM-1:0]    hresp_bus,
  output logic [DW-1:0]     hrdata,
  output logic              hready,
  output logic              hresp,
  output logic [NUM-1:0]    dsel,
  output logic              sel_err
);

  typedef enum logic [1:0] {IDLE, SLV, ERR1, ERR2} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NUM-1:0]   r_dsel;
  logic [NUM-1:0]   w_dsel_nxt;
  logic             r_sel_err;
  logic             w_sel_err_nxt;
  logic             w_hsel_zero;
  logic             w_hsel_onehot;
  logic             w_slv_rdy;
  logic             w_slv_rsp;
  logic [DW-1:0]    w_slv_data;

  assign w_hsel_zero   = (hsel == '0);
  assign w_hsel_onehot = !w_hsel_zero && ((hsel & (hsel - NUM'(1))) == '0);

  // AND-OR mux: unselected slaves are masked out so their X never reaches the master
  always_comb begin
    w_slv_rdy  = 1'b0;
    w_slv_rsp  = 1'b0;
    w_slv_data = '0;
    for (int i = 0; i < NUM; i++) begin
      w_slv_rdy  = w_slv_rdy  | (r_dsel[i] & hreadyout_bus[i]);
      w_slv_rsp  = w_slv_rsp  | (r_dsel[i] & hresp_bus[i]);
      w_slv_data = w_slv_data | ({DW{r_dsel[i]}} & hrdata_bus[i*DW +: DW]);
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (r_state)
      SLV: begin
        hready = w_slv_rdy;
        hresp  = w_slv_rsp;
        hrdata = w_slv_data;
      end
      ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dsel_nxt    = r_dsel;
    w_sel_err_nxt = 1'b0;
    if (r_state == ERR1) begin
      w_state_nxt = ERR2;
    end else if (hready) begin
      if (!htrans_vld) begin
        w_state_nxt = IDLE;
        w_dsel_nxt  = '0;
      end else if (w_hsel_onehot) begin
        w_state_nxt = SLV;
        w_dsel_nxt  = hsel;
      end else begin
        // unmapped and multi-hot both go to the default slave; only multi-hot is flagged
        w_state_nxt   = ERR1;
        w_dsel_nxt    = '0;
        w_sel_err_nxt = !w_hsel_zero;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= IDLE;
      r_dsel    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dsel    <= w_dsel_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

  assign dsel    = r_dsel;
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_ahb_dphase_mux.sv
// Directed bench for ahb_dphase_mux at NUM=6/DW=32, NUM=2/DW=8 and NUM=16/DW=64.
module tb_ahb_dphase_mux;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  // NUM=6, DW=32
  logic [5:0]   hsel6, rdy6_bus, rsp6_bus, dsel6;
  logic         vld6, hready6, hresp6, serr6;
  logic [191:0] rdata6_bus;
  logic [31:0]  hrdata6;
  // NUM=2, DW=8
  logic [1:0]   hsel2, rdy2_bus, rsp2_bus, dsel2;
  logic         vld2, hready2, hresp2, serr2;
  logic [15:0]  rdata2_bus;
  logic [7:0]   hrdata2;
  // NUM=16, DW=64
  logic [15:0]   hsel16, rdy16_bus, rsp16_bus, dsel16;
  logic          vld16, hready16, hresp16, serr16;
  logic [1023:0] rdata16_bus;
  logic [63:0]   hrdata16;

  ahb_dphase_mux #(.NUM(6), .DW(32)) u_dut6 (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel(hsel6), .htrans_vld(vld6),
    .hrdata_bus(rdata6_bus), .hreadyout_bus(rdy6_bus), .hresp_bus(rsp6_bus),
    .hrdata(hrdata6), .hready(hready6), .hresp(hresp6), .dsel(dsel6), .sel_err(serr6));

  ahb_dphase_mux #(.NUM(2), .DW(8)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel(hsel2), .htrans_vld(vld2),
    .hrdata_bus(rdata2_bus), .hreadyout_bus(rdy2_bus), .hresp_bus(rsp2_bus),
    .hrdata(hrdata2), .hready(hready2), .hresp(hresp2), .dsel(dsel2), .sel_err(serr2));

  ahb_dphase_mux #(.NUM(16), .DW(64)) u_dut16 (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel(hsel16), .htrans_vld(vld16),
    .hrdata_bus(rdata16_bus), .hreadyout_bus(rdy16_bus), .hresp_bus(rsp16_bus),
    .hrdata(hrdata16), .hready(hready16), .hresp(hresp16), .dsel(dsel16), .sel_err(serr16));

  typedef struct {
    string       tag;
    int          inst;
    logic        rdy;
    logic        rsp;
    logic        serr;
    logic [15:0] dsel;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [31:0] slice6(int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic [63:0] slice16(int i);
    return {32'hDEAD_BEEF, 32'hA5A5_0000 | 32'(i)};
  endfunction

  task automatic push(string tag, int inst, logic rdy, logic rsp, logic serr,
                      logic [15:0] ds, logic [63:0] rd);
    exp_t e;
    e.tag = tag; e.inst = inst; e.rdy = rdy; e.rsp = rsp;
    e.serr = serr; e.dsel = ds; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic cmp(string tag, string field, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic        o_rdy, o_rsp, o_serr;
    logic [15:0] o_dsel;
    logic [63:0] o_rd;
    if (sb.size() == 0) begin
      n_chk++; n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=entry");
      return;
    end
    e = sb.pop_front();
    case (e.inst)
      0: begin o_rdy = hready6;  o_rsp = hresp6;  o_serr = serr6;
               o_dsel = {10'd0, dsel6}; o_rd = {32'd0, hrdata6}; end
      1: begin o_rdy = hready2;  o_rsp = hresp2;  o_serr = serr2;
               o_dsel = {14'd0, dsel2}; o_rd = {56'd0, hrdata2}; end
      default: begin o_rdy = hready16; o_rsp = hresp16; o_serr = serr16;
               o_dsel = dsel16; o_rd = hrdata16; end
    endcase
    cmp(e.tag, "hready",  {63'd0, o_rdy},  {63'd0, e.rdy});
    cmp(e.tag, "hresp",   {63'd0, o_rsp},  {63'd0, e.rsp});
    cmp(e.tag, "sel_err", {63'd0, o_serr}, {63'd0, e.serr});
    cmp(e.tag, "dsel",    {48'd0, o_dsel}, {48'd0, e.dsel});
    cmp(e.tag, "hrdata",  o_rd,            e.rdata);
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    vld6 = 1'b0; hsel6 = '0; rdy6_bus = '1; rsp6_bus = '0;
    vld2 = 1'b0; hsel2 = '0; rdy2_bus = '1; rsp2_bus = '0;
    vld16 = 1'b0; hsel16 = '0; rdy16_bus = '1; rsp16_bus = '0;
    for (int i = 0; i < 6; i++)  rdata6_bus[i*32 +: 32]  = slice6(i);
    for (int i = 0; i < 2; i++)  rdata2_bus[i*8 +: 8]    = 8'hA0 | 8'(i);
    for (int i = 0; i < 16; i++) rdata16_bus[i*64 +: 64] = slice16(i);

    #12;
    push("reset", 0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0); check_out();
    HRESETn = 1'b1;
    cyc();
    push("idle", 0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0); check_out();

    // single read from slave 2
    vld6 = 1'b1; hsel6 = 6'b000100;
    push("read_s2", 0, 1'b1, 1'b0, 1'b0, 16'h0004, {32'd0, slice6(2)}); cyc(); check_out();
    vld6 = 1'b0; hsel6 = '0;
    push("read_end", 0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0); cyc(); check_out();

    // slave 3 stalls three cycles; a competing select is ignored until hready rises
    vld6 = 1'b1; hsel6 = 6'b001000; rdy6_bus[3] = 1'b0;
    push("wait_1", 0, 1'b0, 1'b0, 1'b0, 16'h0008, {32'd0, slice6(3)}); cyc(); check_out();
    hsel6 = 6'b000001;
    push("wait_2", 0, 1'b0, 1'b0, 1'b0, 16'h0008, {32'd0, slice6(3)}); cyc(); check_out();
    push("wait_3", 0, 1'b0, 1'b0, 1'b0, 16'h0008, {32'd0, slice6(3)}); cyc(); check_out();
    rdy6_bus[3] = 1'b1; #1;
    push("wait_done", 0, 1'b1, 1'b0, 1'b0, 16'h0008, {32'd0, slice6(3)}); check_out();
    push("wait_next", 0, 1'b1, 1'b0, 1'b0, 16'h0001, {32'd0, slice6(0)}); cyc(); check_out();

    // slave-signalled error passes straight through
    hsel6 = 6'b000010; rsp6_bus[1] = 1'b1;
    push("slv_err", 0, 1'b1, 1'b1, 1'b0, 16'h0002, {32'd0, slice6(1)}); cyc(); check_out();
    rsp6_bus[1] = 1'b0;

    // reset asserted mid-transfer with slave 2 stalled
    hsel6 = 6'b000100; rdy6_bus[2] = 1'b0;
    push("stall_s2", 0, 1'b0, 1'b0, 1'b0, 16'h0004, {32'd0, slice6(2)}); cyc(); check_out();
    HRESETn = 1'b0; #1;
    push("reset_mid", 0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0); check_out();
    vld6 = 1'b0; hsel6 = '0; rdy6_bus[2] = 1'b1;
    cyc();
    HRESETn = 1'b1;

    // unmapped address: two-cycle ERROR then idle
    vld6 = 1'b1; hsel6 = '0;
    push("unmap_e1", 0, 1'b0, 1'b1, 1'b0, 16'h0, 64'h0); cyc(); check_out();
    vld6 = 1'b0;
    push("unmap_e2", 0, 1'b1, 1'b1, 1'b0, 16'h0, 64'h0); cyc(); check_out();
    push("unmap_idle", 0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0); cyc(); check_out();

    // multi-hot select: flagged, ERROR, then a new transfer captured off the ERR2 cycle
    vld6 = 1'b1; hsel6 = 6'b010010;
    push("multi_e1", 0, 1'b0, 1'b1, 1'b1, 16'h0, 64'h0); cyc(); check_out();
    hsel6 = 6'b000001;
    push("multi_e2", 0, 1'b1, 1'b1, 1'b0, 16'h0, 64'h0); cyc(); check_out();
    push("after_err", 0, 1'b1, 1'b0, 1'b0, 16'h0001, {32'd0, slice6(0)}); cyc(); check_out();

    // back-to-back slave 0 then slave 5
    hsel6 = 6'b100000;
    push("pipe6_s5", 0, 1'b1, 1'b0, 1'b0, 16'h0020, {32'd0, slice6(5)}); cyc(); check_out();
    vld6 = 1'b0; hsel6 = '0;
    push("pipe6_idle", 0, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0); cyc(); check_out();

    // NUM=2, DW=8
    vld2 = 1'b1; hsel2 = 2'b01;
    push("pipe2_s0", 1, 1'b1, 1'b0, 1'b0, 16'h0001, 64'hA0); cyc(); check_out();
    hsel2 = 2'b10;
    push("pipe2_s1", 1, 1'b1, 1'b0, 1'b0, 16'h0002, 64'hA1); cyc(); check_out();
    vld2 = 1'b0; hsel2 = '0;
    push("pipe2_idle", 1, 1'b1, 1'b0, 1'b0, 16'h0, 64'h0); cyc(); check_out();

    // NUM=16, DW=64
    vld16 = 1'b1; hsel16 = 16'h0001;
    push("pipe16_s0", 2, 1'b1, 1'b0, 1'b0, 16'h0001, slice16(0)); cyc(); check_out();
    hsel16 = 16'h8000;
    push("pipe16_s15", 2, 1'b1, 1'b0, 1'b0, 16'h8000, slice16(15)); cyc(); check_out();
    hsel16 = 16'h0300;
    push("multi16_e1", 2, 1'b0, 1'b1, 1'b1, 16'h0, 64'h0); cyc(); check_out();
    vld16 = 1'b0; hsel16 = '0;
    push("multi16_e2", 2, 1'b1, 1'b1, 1'b0, 16'h0, 64'h0); cyc(); check_out();

    if (sb.size() != 0) begin
      n_chk++; n_err++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
